ex_muldiv_hilo: RTL and testbench

- Parametrised iterative multiply/divide unit in the EX stage, owning the architectural HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake.
- The EX stage holds the pipeline while Busy_EX is high. HI/LO are read continuously, for MFHI/MFLO, via the HI_Out/LO_Out ports.

---
 rtl/mips32_pkg.sv | 26 ++
 rtl/ex_muldiv_hilo_if.sv | 21 ++
 rtl/ex_muldiv_step.sv | 29 ++
 rtl/ex_muldiv_hilo.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_hilo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared mul/div op and FSM state encodings plus op-decode helpers.
package mips32_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;
  function automatic logic is_muldiv(input logic [2:0] op);
    return !op[2];
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_signed_op(input logic [2:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
endpackage

// File: rtl/ex_muldiv_hilo_if.sv
// ex_muldiv_hilo_if: EX-stage request/handshake and HI/LO read bus of the mul/div unit.
interface ex_muldiv_hilo_if #(parameter int WIDTH = 32);
  logic             Start_EX;
  logic [2:0]       Op_EX;
  logic [WIDTH-1:0] Operand_A_EX;
  logic [WIDTH-1:0] Operand_B_EX;
  logic             Flush_EX;
  logic             Busy_EX;
  logic             Done_EX;
  logic             Div_By_Zero_EX;
  logic [WIDTH-1:0] HI_Out;
  logic [WIDTH-1:0] LO_Out;
  modport master (
    output Start_EX, Op_EX, Operand_A_EX, Operand_B_EX, Flush_EX,
    input  Busy_EX, Done_EX, Div_By_Zero_EX, HI_Out, LO_Out
  );
  modport slave (
    input  Start_EX, Op_EX, Operand_A_EX, Operand_B_EX, Flush_EX,
    output Busy_EX, Done_EX, Div_By_Zero_EX, HI_Out, LO_Out
  );
endinterface

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one combinational iteration, shift-add multiply or restoring-divide trial subtract.
// The divide mode only exists when MULDIV_DIV_EN is defined.
module ex_muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic               div_i,
`endif
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_acc;
  assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : '0);
  assign mul_acc = {sum, acc_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] trial;
  logic             ge;
  // Partial remainder stays below the divisor, so a successful trial always fits WIDTH bits.
  assign sh    = acc_i[2*WIDTH-1:WIDTH-1];
  assign ge    = sh >= {1'b0, m_i};
  assign trial = sh[WIDTH-1:0] - m_i;
  assign acc_o = div_i ? {ge ? trial : sh[WIDTH-1:0], acc_i[WIDTH-2:0], ge} : mul_acc;
`else
  assign acc_o = mul_acc;
`endif
endmodule

// File: rtl/ex_muldiv_hilo.sv
// ex_muldiv_hilo: iterative EX-stage multiply/divide unit owning HI/LO (IDLE->PREP->CALC->FIX).
// MULDIV_DIV_EN enables the divider; without it DIV/DIVU complete in FIX with Div_By_Zero_EX set.
module ex_muldiv_hilo
  import mips32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              Clk,
  input logic              Reset,
  ex_muldiv_hilo_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic               qneg_q, qneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  assign sa    = is_signed_op(op_q) & a_q[WIDTH-1];
  assign sb    = is_signed_op(op_q) & b_q[WIDTH-1];
  assign abs_a = sa ? -a_q : a_q;
  assign abs_b = sb ? -b_q : b_q;
  assign prod  = qneg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo, rem;
  assign quo = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .div_i (is_div(op_q)),
`endif
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (step_acc)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    qneg_d  = qneg_q;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
`endif
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    if (bus.Flush_EX) state_d = IDLE;
    else case (state_q)
      IDLE: if (bus.Start_EX) begin
        hi_d = bus.Op_EX == OP_MTHI ? bus.Operand_A_EX : hi_q;
        lo_d = bus.Op_EX == OP_MTLO ? bus.Operand_A_EX : lo_q;
        if (is_muldiv(bus.Op_EX)) begin
          op_d = bus.Op_EX;
          a_d  = bus.Operand_A_EX;
          b_d  = bus.Operand_B_EX;
`ifdef MULDIV_DIV_EN
          state_d = PREP;
`else
          // Unsupported divide dwells two cycles in FIX so Done lands at the same edge as a short op.
          state_d = is_div(bus.Op_EX) ? FIX : PREP;
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      PREP: begin
        state_d = CALC;
        cnt_d   = CNT_W'(WIDTH - 1);
        qneg_d  = sa ^ sb;
`ifdef MULDIV_DIV_EN
        rneg_d  = sa;
`endif
        m_d     = is_div(op_q) ? abs_b : abs_a;
        acc_d   = {{WIDTH{1'b0}}, is_div(op_q) ? abs_a : abs_b};
      end
      CALC: begin
        acc_d   = step_acc;
        state_d = cnt_q == '0 ? FIX : CALC;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
      end
      FIX: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        if (!is_div(op_q)) {hi_d, lo_d} = prod;
        else if (m_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
`else
        if (!is_div(op_q)) {hi_d, lo_d} = prod;
        else dbz_d = 1'b1;
`endif
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
`endif
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
`endif
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  assign bus.Busy_EX        = state_q != IDLE;
  assign bus.Done_EX        = done_q;
  assign bus.Div_By_Zero_EX = dbz_q;
  assign bus.HI_Out         = hi_q;
  assign bus.LO_Out         = lo_q;
endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// tb_ex_muldiv_hilo: table-driven plus scoreboard bench for ex_muldiv_hilo, tracking HI/LO/flag in the bench.
module tb_ex_muldiv_hilo;
  import mips32_pkg::*;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  ex_muldiv_hilo_if #(.WIDTH(W)) bus ();
  ex_muldiv_hilo #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic m_dbz = 1'b0;
  vec_t tbl[11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e_in);
    exp_t e, got;
    int lat, exp_lat;
    logic busy_ok, md, dv;
    e = e_in;
    md = op < 3'd4;
    dv = op == OP_DIV || op == OP_DIVU;
    exp_lat = W + 2;
    if (!md) begin
      e = '{m_hi, m_lo, m_dbz};
      if (op == OP_MTHI) e.hi = a;
      if (op == OP_MTLO) e.lo = a;
    end
`ifndef MULDIV_DIV_EN
    if (dv) begin
      e = '{m_hi, m_lo, 1'b1};
      exp_lat = 2;
    end
`endif
    sbq.push_back(e);
    @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Op_EX = op;
    bus.Operand_A_EX = a;
    bus.Operand_B_EX = b;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    bus.Operand_A_EX = $urandom;
    bus.Operand_B_EX = $urandom;
    if (!md) begin
      got = sbq.pop_front();
      chk({tag, ".busy"}, 64'(bus.Busy_EX), 64'd0);
      chk({tag, ".done"}, 64'(bus.Done_EX), 64'd0);
    end else begin
      lat = 0;
      busy_ok = 1'b1;
      while (!bus.Done_EX && lat < 200) begin
        if (!bus.Busy_EX) busy_ok = 1'b0;
        @(negedge Clk);
        lat++;
      end
      got = sbq.pop_front();
      chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
      chk({tag, ".busy_at_done"}, 64'(bus.Busy_EX), 64'd0);
    end
    chk({tag, ".hi"}, 64'(bus.HI_Out), 64'(got.hi));
    chk({tag, ".lo"}, 64'(bus.LO_Out), 64'(got.lo));
    chk({tag, ".dbz"}, 64'(bus.Div_By_Zero_EX), 64'(got.dbz));
    if (md) begin
      @(negedge Clk);
      chk({tag, ".done_pulse"}, 64'(bus.Done_EX), 64'd0);
    end
    m_hi = got.hi;
    m_lo = got.lo;
    m_dbz = got.dbz;
  endtask
  initial begin
    exp_t e;
    logic signed [63:0] sp;
    logic [63:0] up;
    logic [W-1:0] ra, rb;
    int dn;
    bus.Start_EX = 1'b0;
    bus.Flush_EX = 1'b0;
    bus.Op_EX = '0;
    bus.Operand_A_EX = '0;
    bus.Operand_B_EX = '0;
    // Move/reserved rows take their expectation from the tracked HI/LO state, so their e is unused.
    tbl[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001, 1'b0}};
    tbl[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        '{32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}};
    tbl[2]  = '{OP_MTLO,  32'h12345678, 32'd0,        '{32'd0, 32'd0, 1'b0}};
    tbl[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}};
    tbl[4]  = '{OP_DIVU,  32'd100,      32'd7,        '{32'd2, 32'd14, 1'b0}};
    tbl[5]  = '{OP_DIV,   32'd5,        32'd0,        '{32'd5, 32'hFFFFFFFF, 1'b1}};
    tbl[6]  = '{OP_MTHI,  32'hCAFEF00D, 32'd0,        '{32'd0, 32'd0, 1'b0}};
    tbl[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, '{32'd0, 32'h80000000, 1'b0}};
    tbl[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, '{32'h40000000, 32'd0, 1'b0}};
    tbl[9]  = '{3'd6,     32'h00000001, 32'd1,        '{32'd0, 32'd0, 1'b0}};
    tbl[10] = '{OP_MULTU, 32'd0,        32'h9ABCDEF0, '{32'd0, 32'd0, 1'b0}};
    #12;
    chk("reset.busy", 64'(bus.Busy_EX), 64'd0);
    chk("reset.done", 64'(bus.Done_EX), 64'd0);
    chk("reset.dbz", 64'(bus.Div_By_Zero_EX), 64'd0);
    chk("reset.hi", 64'(bus.HI_Out), 64'd0);
    chk("reset.lo", 64'(bus.LO_Out), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 11; i++) run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      sp = $signed(ra);
      sp = sp * $signed(rb);
      up = {32'd0, ra} * {32'd0, rb};
      e = i % 2 == 0 ? '{sp[63:32], sp[31:0], 1'b0} : '{up[63:32], up[31:0], 1'b0};
      run($sformatf("rmul%0d", i), i % 2 == 0 ? OP_MULT : OP_MULTU, ra, rb, e);
    end
`ifdef MULDIV_DIV_EN
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = W'($urandom_range(1, 50000));
      if (i % 2 == 0) begin
        if (i == 2) rb = -rb;
        e = '{$signed(ra) % $signed(rb), $signed(ra) / $signed(rb), 1'b0};
      end else e = '{ra % rb, ra / rb, 1'b0};
      run($sformatf("rdiv%0d", i), i % 2 == 0 ? OP_DIV : OP_DIVU, ra, rb, e);
    end
`endif
    @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Op_EX = OP_MULTU;
    bus.Operand_A_EX = 32'd9;
    bus.Operand_B_EX = 32'd9;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    repeat (4) @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Operand_A_EX = 32'd1;
    bus.Operand_B_EX = 32'd1;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    repeat (5) @(negedge Clk);
    chk("flush.busy_before", 64'(bus.Busy_EX), 64'd1);
    bus.Flush_EX = 1'b1;
    @(negedge Clk);
    bus.Flush_EX = 1'b0;
    chk("flush.busy_after", 64'(bus.Busy_EX), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done_EX) dn++;
    end
    chk("flush.no_done", 64'(dn), 64'd0);
    chk("flush.hi", 64'(bus.HI_Out), 64'(m_hi));
    chk("flush.lo", 64'(bus.LO_Out), 64'(m_lo));
    @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Op_EX = OP_MULTU;
    bus.Operand_A_EX = 32'd3;
    bus.Operand_B_EX = 32'd4;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    repeat (W + 1) @(negedge Clk);
    chk("fixflush.busy", 64'(bus.Busy_EX), 64'd1);
    bus.Flush_EX = 1'b1;
    @(negedge Clk);
    bus.Flush_EX = 1'b0;
    chk("fixflush.done", 64'(bus.Done_EX), 64'd0);
    chk("fixflush.busy_after", 64'(bus.Busy_EX), 64'd0);
    chk("fixflush.hi", 64'(bus.HI_Out), 64'(m_hi));
    chk("fixflush.lo", 64'(bus.LO_Out), 64'(m_lo));
    @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Flush_EX = 1'b1;
    bus.Op_EX = OP_MTHI;
    bus.Operand_A_EX = 32'hDEADBEEF;
    @(negedge Clk);
    bus.Op_EX = OP_MULTU;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    bus.Flush_EX = 1'b0;
    chk("startflush.hi", 64'(bus.HI_Out), 64'(m_hi));
    chk("startflush.busy", 64'(bus.Busy_EX), 64'd0);
    run("after_flush", OP_MULTU, 32'd3, 32'd4, '{32'd0, 32'd12, 1'b0});
    run("div0", OP_DIV, 32'd5, 32'd0, '{32'd5, 32'hFFFFFFFF, 1'b1});
    @(negedge Clk);
    bus.Start_EX = 1'b1;
    bus.Op_EX = OP_MULTU;
    bus.Operand_A_EX = 32'd1000;
    bus.Operand_B_EX = 32'd1000;
    @(negedge Clk);
    bus.Start_EX = 1'b0;
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midreset.busy", 64'(bus.Busy_EX), 64'd0);
    chk("midreset.done", 64'(bus.Done_EX), 64'd0);
    chk("midreset.dbz", 64'(bus.Div_By_Zero_EX), 64'd0);
    chk("midreset.hi", 64'(bus.HI_Out), 64'd0);
    chk("midreset.lo", 64'(bus.LO_Out), 64'd0);
    m_hi = '0;
    m_lo = '0;
    m_dbz = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    run("post_reset", OP_MULTU, 32'd6, 32'd7, '{32'd0, 32'd42, 1'b0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
